// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: state encoding and default byte width shared by fifo_uart_tx.
// Optional feature macro: FIFO_UART_TX_PARITY_EN adds the PARITY state.
package fifo_uart_pkg;
   localparam int DATA_W_DEF = 8;
`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, READ, LOAD, START, DATA, STOP} state_t;
`endif
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, tick high on the last cycle of every bit.
// Ports: clk, reset (sync, active-low), run (count enable, clears when low),
//        tick (high every CLKS_PER_BIT cycles while run=1).
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   logic [CW-1:0] cnt;
   assign tick = run && cnt == CW'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk)
      if (!reset || !run) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a syn_fifo one byte at a time onto a UART serial line.
// Ports: clk; reset (sync, active-low); empty, data_in from the FIFO;
//        read_e (registered FIFO read strobe); tx (registered serial line, idle high);
//        busy (state not IDLE); tx_done (pulse in the last STOP cycle).
// Optional feature macro: FIFO_UART_TX_PARITY_EN inserts an even-parity bit.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_W       = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              empty,
   input  logic [DATA_W-1:0] data_in,
   output logic              read_e,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);
   localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [IW-1:0]     bit_idx;
   logic              run, tick;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              par;
`endif
   // the bit timer only runs while a frame is on the line
   assign run     = state != IDLE && state != READ && state != LOAD;
   assign busy    = state != IDLE;
   assign tx_done = state == STOP && tick;
   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .reset(reset),
      .run  (run),
      .tick (tick)
   );
   // tx is loaded one edge ahead so each line level holds for the whole state
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         read_e  <= 1'b0;
         shreg   <= '0;
         bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         read_e <= 1'b0;
         case (state)
            IDLE: if (!empty) begin
               state  <= READ;
               read_e <= 1'b1;
            end
            READ: state <= LOAD;
            LOAD: begin
               shreg <= data_in;
`ifdef FIFO_UART_TX_PARITY_EN
               par   <= ^data_in;
`endif
               tx    <= 1'b0;
               state <= START;
            end
            START: if (tick) begin
               tx    <= shreg[0];
               shreg <= shreg >> 1;
               state <= DATA;
            end
            DATA: if (tick) begin
               if (bit_idx == IW'(DATA_W - 1)) begin
                  bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                  tx      <= par;
                  state   <= PARITY;
`else
                  tx      <= 1'b1;
                  state   <= STOP;
`endif
               end else begin
                  bit_idx <= bit_idx + 1'b1;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: if (tick) begin
               tx    <= 1'b1;
               state <= STOP;
            end
`endif
            STOP: if (tick) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed table-driven bench for fifo_uart_tx with a FIFO model.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
   localparam int DW  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       empty;
   logic [7:0] data_in;
   logic       read_e, tx, busy, tx_done;
   logic [7:0] mem [32];
   int         rd = 0, wr = 0, nreads = 0;
   int         checks = 0, failures = 0;
   int         r0, w;
   vec_t       tbl [8];

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
      .clk    (clk),
      .reset  (reset),
      .empty  (empty),
      .data_in(data_in),
      .read_e (read_e),
      .tx     (tx),
      .busy   (busy),
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   // syn_fifo model: data appears on data_in the cycle after read_e
   assign empty = rd == wr;
   always @(posedge clk)
      if (read_e) begin
         nreads <= nreads + 1;
         if (rd != wr) begin
            data_in <= mem[rd];
            rd      <= rd + 1;
         end
      end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr] = b;
      wr = wr + 1;
   endtask

   task automatic wait_read(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         chk("gap_tx_high", 32'(tx), 32'(1));
      end while (!read_e && n < 200);
      chk("read_e_seen", 32'(read_e), 32'(1));
   endtask

   task automatic run_frame(input logic [7:0] d, input logic p, input int gap);
      logic [11:0] bits;
      int nb, n;
      wait_read(n);
      if (!read_e) return;
      if (gap >= 0) chk("gap_cycles", 32'(n), 32'(gap));
      chk("busy_in_read", 32'(busy), 32'(1));
      @(negedge clk);
      chk("load_tx", 32'(tx), 32'(1));
      chk("read_e_one_cycle", 32'(read_e), 32'(0));
      nb = DW + 2 + PAR;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (PAR != 0) bits[9] = p;
      for (int b = 0; b < nb; b++)
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            chk("tx_bit", 32'(tx), 32'(bits[b]));
            chk("tx_done", 32'(tx_done), 32'(b == nb - 1 && c == CPB - 1));
            chk("read_e_in_frame", 32'(read_e), 32'(0));
         end
   endtask

   initial begin
      tbl[0] = '{8'h01, 1'b1};
      tbl[1] = '{8'h09, 1'b0};
      tbl[2] = '{8'h07, 1'b1};
      tbl[3] = '{8'h03, 1'b0};
      tbl[4] = '{8'h04, 1'b1};
      tbl[5] = '{8'h06, 1'b0};
      tbl[6] = '{8'h08, 1'b1};
      tbl[7] = '{8'h0A, 1'b0};
      repeat (3) @(negedge clk);
      chk("reset_tx", 32'(tx), 32'(1));
      chk("reset_read_e", 32'(read_e), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_tx_done", 32'(tx_done), 32'(0));
      reset = 1'b1;
      repeat (100) begin
         @(negedge clk);
         chk("empty_read_e", 32'(read_e), 32'(0));
         chk("empty_tx", 32'(tx), 32'(1));
         chk("empty_busy", 32'(busy), 32'(0));
      end
      // single byte 0x01
      r0 = nreads;
      push(8'h01);
      run_frame(8'h01, 1'b1, -1);
      @(negedge clk);
      chk("single_reads", 32'(nreads - r0), 32'(1));
      chk("single_idle_busy", 32'(busy), 32'(0));
      // preloaded FIFO, back-to-back frames
      r0 = nreads;
      for (int i = 0; i < 8; i++) push(tbl[i].data);
      for (int i = 0; i < 8; i++) run_frame(tbl[i].data, tbl[i].par, i == 0 ? -1 : 2);
      @(negedge clk);
      chk("burst_empty", 32'(empty), 32'(1));
      chk("burst_reads", 32'(nreads - r0), 32'(8));
      chk("burst_idle_busy", 32'(busy), 32'(0));
      // reset in the middle of DATA for 0x09; 0x07 must follow
      push(8'h09);
      push(8'h07);
      wait_read(w);
      repeat (1 + CPB + 3 * CPB) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'(1));
      reset = 1'b0;
      @(negedge clk);
      chk("abort_tx", 32'(tx), 32'(1));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_read_e", 32'(read_e), 32'(0));
      reset = 1'b1;
      run_frame(8'h07, 1'b1, -1);
      @(negedge clk);
      chk("abort_empty", 32'(empty), 32'(1));
      // reset during READ: one FIFO read, no frame while held
      push(8'h04);
      push(8'h06);
      wait_read(w);
      r0 = nreads;
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("rd_rst_read_e", 32'(read_e), 32'(0));
         chk("rd_rst_busy", 32'(busy), 32'(0));
         chk("rd_rst_tx", 32'(tx), 32'(1));
      end
      chk("rd_rst_reads", 32'(nreads - r0), 32'(1));
      reset = 1'b1;
      run_frame(8'h06, 1'b0, -1);
      @(negedge clk);
      chk("rd_rst_total_reads", 32'(nreads - r0), 32'(2));
      chk("final_busy", 32'(busy), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
